// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame transmitter and the demux controller.
// Frame layout: start bit, port field, length field, then L payload bits, all MSB first.
package serial_frame_pkg;

   localparam int   PORT_W    = 2;
   localparam int   LEN_W     = 4;
   localparam logic START_BIT = 1'b0;
   localparam logic IDLE_LVL  = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_PORT,
      S_LEN,
      S_DATA,
      S_GAP
   } state_t;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Request handshake plus serial line/status for the frame transmitter.
// The master side is the traffic source; the slave side is the transmitter.
interface serial_frame_tx_if #(
   parameter int PORT_W = 2,
   parameter int LEN_W  = 4,
   parameter int DATA_W = 16
);

   logic              req_valid;
   logic              req_ready;
   logic [PORT_W-1:0] req_port;
   logic [LEN_W-1:0]  req_len;
   logic [DATA_W-1:0] req_data;
   logic              ser_out;
   logic              busy;
   logic              frame_done;

   modport master (
      output req_valid, req_port, req_len, req_data,
      input  req_ready, ser_out, busy, frame_done
   );

   modport slave (
      input  req_valid, req_port, req_len, req_data,
      output req_ready, ser_out, busy, frame_done
   );

endinterface

// File: rtl/frame_bit_counter.sv
// Loadable down-counter with enable and zero flag; it saturates at zero.
// Shared by every field of the frame and by the inter-frame gap.
module frame_bit_counter #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic [W-1:0] o_cnt,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_en) begin
         if (i_load)
            r_cnt <= i_load_val;
         else if (r_cnt != '0)
            r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// Serialises one {port, len, data} request per frame onto a single idle-high line.
// Payload is left-aligned at accept so the whole frame drains from one shift register MSB.
module serial_frame_tx
   import serial_frame_pkg::*;
#(
   parameter int PORT_W   = serial_frame_pkg::PORT_W,
   parameter int LEN_W    = serial_frame_pkg::LEN_W,
   parameter int DATA_W   = 16,
   parameter int IDLE_GAP = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clkEn,
   serial_frame_tx_if.slave bus
);

   localparam int CNT_W = LEN_W + 1;
   localparam int SH_W  = PORT_W + LEN_W + DATA_W;
   localparam int SA_W  = $clog2(DATA_W + 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [SH_W-1:0]   r_sh;
   logic [LEN_W-1:0]  r_len;
   logic              w_accept;
   logic              w_cnt_ld;
   logic [CNT_W-1:0]  w_cnt_val;
   logic [CNT_W-1:0]  w_cnt;
   logic              w_cnt_zero;
   logic [SA_W-1:0]   w_shamt;
   logic [DATA_W-1:0] w_data_al;

   assign w_accept  = clkEn & bus.req_valid & (r_state == S_IDLE);
   // Push data[L-1] up to the payload MSB; bits above L fall off the top.
   assign w_shamt   = SA_W'(DATA_W) - SA_W'(bus.req_len);
   assign w_data_al = bus.req_data << w_shamt;

   frame_bit_counter #(.W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .i_en      (clkEn),
      .i_load    (w_cnt_ld),
      .i_load_val(w_cnt_val),
      .o_cnt     (w_cnt),
      .o_zero    (w_cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (!rst)
         r_state <= S_IDLE;
      else if (clkEn)
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sh  <= '0;
         r_len <= '0;
      end else if (clkEn) begin
         if (w_accept) begin
            r_sh  <= {bus.req_port, bus.req_len, w_data_al};
            r_len <= bus.req_len;
         end else if (r_state inside {S_PORT, S_LEN, S_DATA}) begin
            r_sh  <= {r_sh[SH_W-2:0], 1'b0};
         end
      end
   end

   // Counter is reloaded on the edge that enters each counted state.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_ld    = 1'b0;
      w_cnt_val   = '0;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_START;
         S_START: begin
            w_state_nxt = S_PORT;
            w_cnt_ld    = 1'b1;
            w_cnt_val   = CNT_W'(PORT_W - 1);
         end
         S_PORT:  if (w_cnt_zero) begin
            w_state_nxt = S_LEN;
            w_cnt_ld    = 1'b1;
            w_cnt_val   = CNT_W'(LEN_W - 1);
         end
         S_LEN:   if (w_cnt_zero) begin
            w_cnt_ld = 1'b1;
            if (r_len == '0) begin
               w_state_nxt = S_GAP;
               w_cnt_val   = CNT_W'(IDLE_GAP - 1);
            end else begin
               w_state_nxt = S_DATA;
               w_cnt_val   = {1'b0, r_len} - CNT_W'(1);
            end
         end
         S_DATA:  if (w_cnt_zero) begin
            w_state_nxt = S_GAP;
            w_cnt_ld    = 1'b1;
            w_cnt_val   = CNT_W'(IDLE_GAP - 1);
         end
         S_GAP:   if (w_cnt_zero) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.ser_out    = IDLE_LVL;
      bus.busy       = 1'b0;
      bus.req_ready  = 1'b0;
      bus.frame_done = 1'b0;
      case (r_state)
         S_IDLE:  bus.req_ready = 1'b1;
         S_START: begin
            bus.ser_out = START_BIT;
            bus.busy    = 1'b1;
         end
         S_PORT, S_LEN, S_DATA: begin
            bus.ser_out = r_sh[SH_W-1];
            bus.busy    = 1'b1;
         end
         S_GAP:   bus.frame_done = (w_cnt == CNT_W'(IDLE_GAP - 1));
         default: ;
      endcase
   end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: per-cycle vector tables for whole frames,
// plus hand sequences for reset mid-frame and back-to-back requests.
module tb_serial_frame_tx;

   logic clk = 1'b0;
   logic rst;
   logic clkEn;

   serial_frame_tx_if #(.PORT_W(2), .LEN_W(4), .DATA_W(16)) bus ();

   serial_frame_tx #(.PORT_W(2), .LEN_W(4), .DATA_W(16), .IDLE_GAP(2)) dut (
      .clk  (clk),
      .rst  (rst),
      .clkEn(clkEn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic en;
      logic ser;
      logic busy;
      logic done;
      logic rdy;
   } vec_t;

   vec_t base[$];
   vec_t len0[$];
   vec_t q[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic vec_t mk(input logic en, s, b, d, r);
      vec_t v;
      v.en = en; v.ser = s; v.busy = b; v.done = d; v.rdy = r;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic s, b, d, r);
      chk({tag, ".ser_out"},    bus.ser_out,    s);
      chk({tag, ".busy"},       bus.busy,       b);
      chk({tag, ".frame_done"}, bus.frame_done, d);
      chk({tag, ".req_ready"},  bus.req_ready,  r);
   endtask

   task automatic run_q(input string tag);
      foreach (q[i]) begin
         check_out($sformatf("%s[%0d]", tag, i), q[i].ser, q[i].busy, q[i].done, q[i].rdy);
         clkEn = q[i].en;
         tick();
      end
      clkEn = 1'b1;
   endtask

   // Accept a request, then scramble the inputs to prove they were latched.
   task automatic accept(input logic [1:0] p, input logic [3:0] l, input logic [15:0] d);
      chk("ready_before_accept", bus.req_ready, 1'b1);
      bus.req_valid = 1'b1;
      bus.req_port  = p;
      bus.req_len   = l;
      bus.req_data  = d;
      clkEn         = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      bus.req_port  = ~p;
      bus.req_len   = ~l;
      bus.req_data  = ~d;
   endtask

   task automatic push_tail(inout vec_t t[$]);
      t.push_back(mk(1, 1, 0, 1, 0));
      t.push_back(mk(1, 1, 0, 0, 0));
      t.push_back(mk(1, 1, 0, 0, 1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] bits_a;
      logic [6:0]  bits_z;
      logic [36:0] exp6, got6;
      logic [1:0]  p6[3];
      logic [3:0]  l6[3];
      logic [15:0] d6[3];
      int          acc, busyc;
      logic        take;

      // port=2, len=5, data=0x13 -> start, 10, 0101, 10011
      bits_a = 12'b0_10_0101_10011;
      for (int i = 0; i < 12; i++) base.push_back(mk(1, bits_a[11-i], 1, 0, 0));
      push_tail(base);
      // port=3, len=0 -> start, 11, 0000
      bits_z = 7'b0_11_0000;
      for (int i = 0; i < 7; i++) len0.push_back(mk(1, bits_z[6-i], 1, 0, 0));
      push_tail(len0);

      rst = 1'b0; clkEn = 1'b1;
      bus.req_valid = 1'b0; bus.req_port = '0; bus.req_len = '0; bus.req_data = '0;
      repeat (3) tick();
      check_out("reset", 1, 0, 0, 1);
      rst = 1'b1;
      tick();
      check_out("idle_after_reset", 1, 0, 0, 1);

      accept(2'd2, 4'd5, 16'h0013);
      q = base;
      run_q("frame_a");

      accept(2'd3, 4'd0, 16'hFFFF);
      q = len0;
      run_q("frame_len0");

      // clkEn pattern 1,0,0,1 around the second data bit
      accept(2'd2, 4'd5, 16'h0013);
      q = base;
      q.insert(8, mk(0, 0, 1, 0, 0));
      q.insert(8, mk(0, 0, 1, 0, 0));
      run_q("frame_clken");

      // Reset lands while the third data bit is on the line; clkEn low too.
      accept(2'd2, 4'd5, 16'h0013);
      q = base[0:8];
      run_q("frame_cut");
      check_out("third_data_bit", 0, 1, 0, 0);
      rst = 1'b0; clkEn = 1'b0;
      tick();
      check_out("mid_frame_reset", 1, 0, 0, 1);
      rst = 1'b1; clkEn = 1'b1;
      tick();
      check_out("no_resend", 1, 0, 0, 1);
      accept(2'd2, 4'd5, 16'h0013);
      q = base;
      run_q("frame_after_rst");

      // Three queued requests with req_valid held high.
      p6 = '{2'd1, 2'd0, 2'd3};
      l6 = '{4'd2, 4'd1, 4'd3};
      d6 = '{16'hFFF2, 16'h8001, 16'h7FFD};
      exp6 = 37'b1_001001010_111_00000011_111_0110011101_11_1;
      acc = 0; busyc = 0; got6 = '0;
      bus.req_valid = 1'b1;
      bus.req_port = p6[0]; bus.req_len = l6[0]; bus.req_data = d6[0];
      for (int i = 0; i < 37; i++) begin
         got6[36-i] = bus.ser_out;
         if (bus.busy) busyc++;
         take = bus.req_ready & bus.req_valid;
         tick();
         if (take) begin
            acc++;
            if (acc < 3) begin
               bus.req_port = p6[acc]; bus.req_len = l6[acc]; bus.req_data = d6[acc];
            end else begin
               bus.req_valid = 1'b0;
            end
         end
      end
      chk("b2b_line", got6, exp6);
      chk("b2b_accepts", acc, 3);
      chk("b2b_busy_cycles", busyc, 27);
      check_out("b2b_end", 1, 0, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
